// File: rtl/wptr_level_handler_pkg.sv
// ---------------------------------------------------------------------------
// wptr_level_handler_pkg
// Shared definitions for the async-FIFO pointer handlers:
//   PTR_WIDTH_DEF / AFULL_LVL_DEF : default pointer width and almost-full level
//   GRAY_MAX_W                    : widest pointer (PTR_WIDTH=10 plus wrap bit)
//   bin2gray / gray2bin           : width-generic code converters; callers
//                                   zero-extend into gray_word_t and truncate
//                                   the result back to their own width
// ---------------------------------------------------------------------------
package wptr_level_handler_pkg;

  localparam int PTR_WIDTH_DEF = 3;
  localparam int AFULL_LVL_DEF = 6;
  localparam int GRAY_MAX_W    = 11;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Zero-extension does not disturb the low bits: the top real bit is
  // XORed with a zero, which is exactly the Gray MSB rule.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_level_handler_gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter of width W.
//   gray_i : Gray-coded input
//   bin_o  : binary equivalent
// Each binary bit is the XOR of all Gray bits from the MSB down to itself,
// written as independent reductions so there is no ripple dependency
// between output bits.
// ---------------------------------------------------------------------------
module gray2bin
  import wptr_level_handler_pkg::*;
#(
  parameter int W = PTR_WIDTH_DEF + 1
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/wptr_level_handler.sv
// ---------------------------------------------------------------------------
// wptr_level_handler
// Write-domain half of an asynchronous FIFO: owns the write pointer, derives
// full / almost-full / occupancy against the synchronised read pointer, and
// keeps a sticky overflow flag.
//   wr_clk, wr_rst_n : write clock, asynchronous active-low reset
//   wr_en_i          : write request
//   ovf_clr_i        : clears the sticky overflow flag
//   g_rptr_sync_i    : Gray read pointer already in the wr_clk domain
//   wr_push_o        : combinational RAM write strobe (accepted write)
//   b_wptr_o         : binary write pointer, low PTR_WIDTH bits address RAM
//   g_wptr_o         : Gray write pointer for the read-side synchroniser
//   full_o           : FIFO full
//   almost_full_o    : occupancy >= AFULL_LVL
//   wr_level_o       : write-side occupancy, 0..DEPTH
//   overflow_o       : sticky, write attempted while full
// ---------------------------------------------------------------------------
module wptr_level_handler
  import wptr_level_handler_pkg::*;
#(
  parameter int PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int AFULL_LVL = AFULL_LVL_DEF
) (
  input  logic               wr_clk,
  input  logic               wr_rst_n,
  input  logic               wr_en_i,
  input  logic               ovf_clr_i,
  input  logic [PTR_WIDTH:0] g_rptr_sync_i,
  output logic               wr_push_o,
  output logic [PTR_WIDTH:0] b_wptr_o,
  output logic [PTR_WIDTH:0] g_wptr_o,
  output logic               full_o,
  output logic               almost_full_o,
  output logic [PTR_WIDTH:0] wr_level_o,
  output logic               overflow_o
);

  localparam int W = PTR_WIDTH + 1;
  localparam logic [W-1:0] AFULL_THR = W'(AFULL_LVL);

  logic [W-1:0] b_wptr_q, b_wptr_d;
  logic [W-1:0] g_wptr_q, g_wptr_d;
  logic [W-1:0] level_q, level_d;
  logic         full_q, full_d;
  logic         afull_q, afull_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] b_rptr_sync;
  logic         push;

  gray2bin #(.W(W)) u_rptr_g2b (
    .gray_i (g_rptr_sync_i),
    .bin_o  (b_rptr_sync)
  );

  // full_q gates the strobe, so a write can never land in an occupied slot;
  // a stale read pointer can only make full_q linger, never clear early.
  assign push = wr_en_i & ~full_q;

  // Next-state evaluation. Full is the classic Gray test: write pointer one
  // lap ahead means the top two Gray bits are inverted and the rest equal.
  // Level uses modular subtraction, so pointer wrap needs no special case.
  always_comb begin
    b_wptr_d = b_wptr_q + W'(push);
    g_wptr_d = W'(bin2gray(GRAY_MAX_W'(b_wptr_d)));
    full_d   = (g_wptr_d == {~g_rptr_sync_i[PTR_WIDTH:PTR_WIDTH-1],
                             g_rptr_sync_i[PTR_WIDTH-2:0]});
    level_d  = b_wptr_d - b_rptr_sync;
    afull_d  = (level_d >= AFULL_THR);
    ovf_d    = ovf_q;
    if (wr_en_i && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_push_o     = push;
  assign b_wptr_o      = b_wptr_q;
  assign g_wptr_o      = g_wptr_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;
  assign wr_level_o    = level_q;
  assign overflow_o    = ovf_q;

endmodule

// File: doc/wptr_level_handler.md
WPTR_LEVEL_HANDLER -- requirements
Module: wptr_level_handler

Interface
REQ-001 The block SHALL have one clock, wr_clk; reset is wr_rst_n, asynchronous and active-low.
REQ-002 Parameter PTR_WIDTH SHALL default to 3, meaning log2 of FIFO depth (DEPTH = 2^PTR_WIDTH), legal range 2..10.
REQ-003 Parameter AFULL_LVL SHALL default to 6, meaning the occupancy at or above which almost_full_o asserts, legal range 1..DEPTH.
REQ-004 wr_clk  input  1  write-domain clock.
REQ-005 wr_rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_en_i  input  1  write request.
REQ-007 ovf_clr_i  input  1  clears the sticky overflow flag.
REQ-008 g_rptr_sync_i  input  PTR_WIDTH+1  Gray read pointer, already synchronised into wr_clk.
REQ-009 wr_push_o  output  1  combinational memory write strobe (accepted write).
REQ-010 b_wptr_o  output  PTR_WIDTH+1  binary write pointer; low PTR_WIDTH bits are the RAM address.
REQ-011 g_wptr_o  output  PTR_WIDTH+1  Gray write pointer, for the read-domain synchroniser.
REQ-012 full_o  output  1  FIFO full.
REQ-013 almost_full_o  output  1  occupancy >= AFULL_LVL.
REQ-014 wr_level_o  output  PTR_WIDTH+1  write-side occupancy, 0..DEPTH.
REQ-015 overflow_o  output  1  sticky flag: write attempted while full.

Function
REQ-016 wr_push_o SHALL equal wr_en_i AND NOT full_o, with no registering.
REQ-017 b_wptr_next SHALL equal b_wptr_o + wr_push_o, modulo 2^(PTR_WIDTH+1); g_wptr_next SHALL equal b_wptr_next XOR (b_wptr_next >> 1).
REQ-018 b_wptr_o and g_wptr_o SHALL load b_wptr_next and g_wptr_next on every wr_clk rising edge, and SHALL hold when wr_push_o=0.
REQ-019 full_o SHALL register (g_wptr_next == {~g_rptr_sync_i[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync_i[PTR_WIDTH-2:0]}).
REQ-020 The block SHALL convert g_rptr_sync_i combinationally to binary b_rptr_sync (prefix XOR from the MSB).
REQ-021 wr_level_o SHALL register (b_wptr_next - b_rptr_sync) modulo 2^(PTR_WIDTH+1).
REQ-022 almost_full_o SHALL register (level_next >= AFULL_LVL).
REQ-023 Latency: all registered outputs SHALL reflect an accepted write, or a read-pointer change, on the first wr_clk edge after it.
REQ-024 full_o SHALL be 1 exactly when wr_level_o == DEPTH; wr_level_o SHALL never exceed DEPTH.
REQ-025 Synchroniser lag SHALL only overstate occupancy; the block SHALL never permit a write into an occupied slot.
REQ-026 overflow_o SHALL set on any edge where wr_en_i=1 and full_o=1; ovf_clr_i SHALL clear it; on simultaneous set and clear, set SHALL win.
REQ-027 Pointer wrap from 2^(PTR_WIDTH+1)-1 to 0 SHALL be seamless and SHALL cause no spurious full_o or level glitch.

Reset
REQ-028 While wr_rst_n=0, b_wptr_o, g_wptr_o, wr_level_o, full_o, almost_full_o and overflow_o SHALL be 0, asynchronously.
REQ-029 A reset asserted mid-burst SHALL abort the burst immediately; after release, the block SHALL behave as an empty FIFO relative to g_rptr_sync_i.

Structure
REQ-030 A shared package SHALL hold the default PTR_WIDTH and AFULL_LVL constants, and a bin2gray/gray2bin function pair shared with the read-side handler.
REQ-031 Gray-to-binary conversion SHALL be one parametrised sub-module, gray2bin #(W), instantiated once.

Verification (PTR_WIDTH=3, AFULL_LVL=6)
REQ-032 Reset: assert wr_rst_n=0 with wr_en_i=1 -> all outputs 0, wr_push_o=0 after release until the first write.
REQ-033 Fill: g_rptr_sync_i=0, 8 consecutive writes -> almost_full_o=1 after the 6th edge; after the 8th edge full_o=1, wr_level_o=8, b_wptr_o=8, g_wptr_o=4'b1100.
REQ-034 Overflow: write while full -> wr_push_o=0, pointers hold, overflow_o=1 next edge; ovf_clr_i alone -> 0; ovf_clr_i with a write while full -> stays 1.
REQ-035 Drain: when full, set g_rptr_sync_i=4'b0010 (binary 3) -> next edge full_o=0, wr_level_o=5, almost_full_o=0.
REQ-036 Wrap: 20 writes with g_rptr_sync_i tracking the write pointer one cycle late -> b_wptr_o wraps 15->0, g_wptr_o 4'b1000->4'b0000, full_o never 1, wr_level_o <= 1.
REQ-037 Mid-burst reset: drop wr_rst_n after the 4th write -> outputs 0 immediately; writes resume from b_wptr_o=0 after release.
